apb3_region_bridge: RTL and testbench



---
 rtl/apb3_region_bridge.sv | 179 +++++++++++++++++
 tb/tb_apb3_region_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_region_bridge.sv
// APB3 one-to-N bridge: decodes an upstream transfer into one of NUM_SLV regions by an
// ascending base table and runs a registered downstream SETUP/ACCESS sequence with timeout.
module apb3_region_bridge #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLV = 3,
    parameter int unsigned IDX_LSB = 2,
    parameter int unsigned IDX_BITS = 5,
    parameter logic [NUM_SLV*IDX_BITS-1:0] BASE_LIST = {5'd15, 5'd11, 5'd5},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic                          PWRITE,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    output logic                          PREADY,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PSLVERR,
    output logic [NUM_SLV-1:0]            m_psel,
    output logic                          m_penable,
    output logic [ADDR_WIDTH-1:0]         m_paddr,
    output logic                          m_pwrite,
    output logic [DATA_WIDTH-1:0]         m_pwdata,
    input  logic [NUM_SLV-1:0]            m_pready,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] m_prdata,
    input  logic [NUM_SLV-1:0]            m_pslverr
);

    localparam int unsigned SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDSetup, StDAccess, StResp} state_e;

    state_e                 state_q, state_d;
    logic [SLV_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_BITS-1:0]    addr_idx;
    logic                   dec_hit;
    logic [SLV_W-1:0]       dec_idx;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   pready_d, pslverr_d, penable_d, pwrite_d;
    logic [DATA_WIDTH-1:0]  prdata_d, pwdata_d;
    logic [ADDR_WIDTH-1:0]  paddr_d;
    logic [NUM_SLV-1:0]     psel_d;

    function automatic logic [NUM_SLV-1:0] to_onehot(input logic [SLV_W-1:0] sel);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == SLV_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign addr_idx = PADDR[IDX_LSB +: IDX_BITS];

    // Bases ascend, so the highest base not above idx owns it.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (addr_idx >= BASE_LIST[i*IDX_BITS +: IDX_BITS]) begin
                dec_hit = 1'b1;
                dec_idx = SLV_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == SLV_W'(i)) begin
                sel_ready = m_pready[i];
                sel_err   = m_pslverr[i];
                sel_rdata = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        paddr_d   = m_paddr;
        pwrite_d  = m_pwrite;
        pwdata_d  = m_pwdata;
        psel_d    = '0;
        penable_d = 1'b0;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    paddr_d  = PADDR;
                    pwrite_d = PWRITE;
                    pwdata_d = PWDATA;
                    idx_d    = dec_idx;
                    if (dec_hit) begin
                        state_d = StDSetup;
                        psel_d  = to_onehot(dec_idx);
                    end else begin
                        state_d   = StResp;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end
            end
            StDSetup: begin
                state_d   = StDAccess;
                psel_d    = to_onehot(idx_q);
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StDAccess: begin
                if (sel_ready) begin
                    state_d   = StResp;
                    pready_d  = 1'b1;
                    prdata_d  = m_pwrite ? '0 : sel_rdata;
                    pslverr_d = sel_err;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_d   = StResp;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        psel_d    = to_onehot(idx_q);
                        penable_d = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            PREADY    <= pready_d;
            PRDATA    <= prdata_d;
            PSLVERR   <= pslverr_d;
            m_psel    <= psel_d;
            m_penable <= penable_d;
            m_paddr   <= paddr_d;
            m_pwrite  <= pwrite_d;
            m_pwdata  <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb3_region_bridge.sv
// Directed bench for apb3_region_bridge: scoreboarded upstream responses plus per-cycle
// checks of the downstream select/enable sequence, timeout and mid-transfer reset.
module tb_apb3_region_bridge;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             PSEL, PENABLE, PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic             PREADY, PSLVERR;
    logic [DW-1:0]    PRDATA;
    logic [NS-1:0]    m_psel;
    logic             m_penable;
    logic [AW-1:0]    m_paddr;
    logic             m_pwrite;
    logic [DW-1:0]    m_pwdata;
    logic [NS-1:0]    m_pready;
    logic [NS*DW-1:0] m_prdata;
    logic [NS-1:0]    m_pslverr;

    logic [DW-1:0]    sdata [NS];
    logic [NS-1:0]    err_cfg;
    int               wait_cfg;
    logic [7:0]       pen_cnt;
    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;

    apb3_region_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_SLV        (NS),
        .IDX_LSB        (2),
        .IDX_BITS       (5),
        .BASE_LIST      ({5'd15, 5'd11, 5'd5}),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_paddr   (m_paddr),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata),
        .m_pslverr (m_pslverr)
    );

    // Slave model: a selected slave answers after wait_cfg enable cycles.
    always_ff @(posedge clk) begin
        if (!resetn || !m_penable) pen_cnt <= '0;
        else pen_cnt <= pen_cnt + 8'd1;
    end

    always_comb begin
        m_pready = '0;
        for (int i = 0; i < NS; i++) begin
            m_pready[i] = m_penable && m_psel[i] && (int'(pen_cnt) == wait_cfg);
        end
    end

    assign m_prdata  = {sdata[2], sdata[1], sdata[0]};
    assign m_pslverr = err_cfg;

    function automatic int exp_slave(input logic [AW-1:0] a);
        int idx;
        idx = int'(a[6:2]);
        if (idx >= 15) return 2;
        if (idx >= 11) return 1;
        if (idx >= 5) return 0;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pready"}, DW'(PREADY), '0);
        chk({tag, "_prdata"}, PRDATA, '0);
        chk({tag, "_pslverr"}, DW'(PSLVERR), '0);
        chk({tag, "_m_psel"}, DW'(m_psel), '0);
        chk({tag, "_m_penable"}, DW'(m_penable), '0);
        chk({tag, "_m_paddr"}, DW'(m_paddr), '0);
        chk({tag, "_m_pwrite"}, DW'(m_pwrite), '0);
        chk({tag, "_m_pwdata"}, m_pwdata, '0);
    endtask

    task automatic do_xfer(input string tag, input logic [AW-1:0] addr, input logic wr,
                           input logic [DW-1:0] wd, input int waits);
        exp_t          e;
        exp_t          got;
        int            s;
        int            nacc;
        int            cyc;
        logic          done;
        logic [NS-1:0] oh;
        s    = exp_slave(addr);
        nacc = (s < 0) ? 0 : ((waits >= TO) ? TO : waits + 1);
        e.lat   = (s < 0) ? 1 : 2 + nacc;
        e.err   = (s < 0 || waits >= TO) ? 1'b1 : err_cfg[s];
        e.rdata = (s < 0 || waits >= TO || wr) ? '0 : sdata[s];
        sb.push_back(e);
        oh = (s < 0) ? '0 : NS'(1) << s;
        wait_cfg = waits;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            PENABLE = 1'b1;
            chk({tag, "_m_psel"}, DW'(m_psel), DW'((cyc <= 1 + nacc) ? oh : '0));
            chk({tag, "_m_penable"}, DW'(m_penable), DW'(s >= 0 && cyc >= 2 && cyc <= 1 + nacc));
            if (cyc == 1 && s >= 0) begin
                chk({tag, "_m_paddr"}, DW'(m_paddr), DW'(addr));
                chk({tag, "_m_pwrite"}, DW'(m_pwrite), DW'(wr));
                chk({tag, "_m_pwdata"}, m_pwdata, wd);
            end
            if (PREADY) begin
                done = 1'b1;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk({tag, "_latency"}, DW'(cyc), DW'(got.lat));
                    chk({tag, "_prdata"}, PRDATA, got.rdata);
                    chk({tag, "_pslverr"}, DW'(PSLVERR), DW'(got.err));
                end
            end
        end
        chk({tag, "_completed"}, DW'(done), DW'(1));
        if (!done) sb.delete();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        chk({tag, "_pready_clr"}, DW'(PREADY), '0);
        chk({tag, "_prdata_clr"}, PRDATA, '0);
        chk({tag, "_pslverr_clr"}, DW'(PSLVERR), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sdata[0] = 32'h1111_0000;
        sdata[1] = 32'hA5A5_0001;
        sdata[2] = 32'h2222_0002;
        err_cfg  = '0;
        wait_cfg = 0;
        resetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        do_xfer("rd_hit_s1", 16'h002C, 1'b0, 32'h0000_0000, 0);
        do_xfer("idx5_s0", 16'h0014, 1'b0, 32'h1234_5678, 0);
        do_xfer("idx10_s0", 16'h0028, 1'b0, 32'h0, 1);
        do_xfer("idx15_s2", 16'h003C, 1'b0, 32'h0, 0);
        do_xfer("idx31_s2", 16'h007C, 1'b0, 32'h0, 2);
        do_xfer("miss_idx4", 16'h0010, 1'b0, 32'h0, 0);
        do_xfer("miss_idx0", 16'h0000, 1'b1, 32'h5555_AAAA, 0);

        err_cfg = 3'b100;
        do_xfer("wr_wait3_s2", 16'h003C, 1'b1, 32'hDEAD_BEEF, 3);
        err_cfg = 3'b010;
        do_xfer("rd_err_s1", 16'h0030, 1'b0, 32'h0, 0);
        err_cfg = '0;

        do_xfer("timeout_s0", 16'h0014, 1'b0, 32'h0, 1000);
        do_xfer("after_to_s1", 16'h002C, 1'b0, 32'h0, 0);

        // ACCESS-phase pattern without a preceding SETUP must not start a transfer.
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 16'h002C;
        tick();
        tick();
        chk("ignored_pready", DW'(PREADY), '0);
        chk("ignored_m_psel", DW'(m_psel), '0);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();

        wait_cfg = 1000;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h002C; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
        tick();
        PENABLE = 1'b1;
        tick();
        chk("rst_mid_in_access", DW'(m_penable), DW'(1));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk_all_zero("rst_mid");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_no_pready", DW'(PREADY), '0);
            chk("rst_mid_no_psel", DW'(m_psel), '0);
        end
        do_xfer("after_rst_s2", 16'h0040, 1'b0, 32'h0, 1);

        chk("scoreboard_empty", DW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
